// File: rtl/hdpldadapt_cmn_cp_comp_dly.sv
// Per-channel control compensation delay: re-times a distributed control tap by D enabled cycles.
// Optional sticky overlap error flag is built only when HDPLDADAPT_CP_COMP_ERR_EN is defined.
module hdpldadapt_cmn_cp_comp_dly #(
  parameter int   WIDTH     = 1,
  parameter int   MAX_DLY   = 15,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             data_enable,
  input  logic [WIDTH-1:0] dist_tap,
  input  logic             r_comp_en,
  input  logic [3:0]       r_comp_dly,
  output logic [WIDTH-1:0] comp_out,
  output logic             comp_busy,
  output logic             comp_err
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;
  localparam logic [3:0] MAX_D   = 4'(MAX_DLY);

  // stg_q[k-1] holds stage k; stage 1 is the most recently captured tap
  logic [MAX_DLY-1:0][WIDTH-1:0] stg_q, stg_d;
  logic [0:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] dly_eff, dly_m1;
  logic       comp_act, capture;

  assign dly_eff  = (r_comp_dly > MAX_D) ? MAX_D : r_comp_dly;
  assign dly_m1   = dly_eff - 4'd1;
  assign comp_act = r_comp_en && (dly_eff != 4'd0);
  assign capture  = comp_act && data_enable && (dist_tap != stg_q[0]);

  always_comb begin
    comp_out = dist_tap;
    for (int k = 0; k < MAX_DLY; k++)
      if (comp_act && (dly_m1 == 4'(k))) comp_out = stg_q[k];
  end

  always_comb begin
    stg_d = stg_q;
    if (data_enable) begin
      stg_d[0] = dist_tap;
      for (int k = 1; k < MAX_DLY; k++) stg_d[k] = stg_q[k-1];
    end
  end

  // A capture while pending restarts the window so the busy flag spans the latest edge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!r_comp_en) begin
      state_d = ST_IDLE;
      cnt_d   = 4'd0;
    end else if (data_enable) begin
      case (state_q)
        ST_IDLE: begin
          if (capture) begin
            state_d = ST_PEND;
            cnt_d   = dly_m1;
          end
        end
        ST_PEND: begin
          if (capture)             cnt_d   = dly_m1;
          else if (cnt_q == 4'd0)  state_d = ST_IDLE;
          else                     cnt_d   = cnt_q - 4'd1;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      stg_q   <= {MAX_DLY{{WIDTH{RESET_VAL}}}};
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      stg_q   <= stg_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign comp_busy = (state_q == ST_PEND);

`ifdef HDPLDADAPT_CP_COMP_ERR_EN
  logic err_q, err_d;

  assign err_d = err_q | (capture && (state_q == ST_PEND));

  always_ff @(posedge clk) begin
    if (srst) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign comp_err = err_q;
`else
  assign comp_err = 1'b0;
`endif

endmodule

// File: tb/tb_hdpldadapt_cmn_cp_comp_dly.sv
// Bench for hdpldadapt_cmn_cp_comp_dly: history-queue model compared every cycle, plus directed literals.
module tb_hdpldadapt_cmn_cp_comp_dly;

  localparam int   W    = 2;
  localparam int   MAXD = 8;
  localparam logic RV   = 1'b0;
`ifdef HDPLDADAPT_CP_COMP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic         clk;
  logic         srst;
  logic         de;
  logic [W-1:0] tap;
  logic         en;
  logic [3:0]   dly;
  logic [W-1:0] comp_out;
  logic         comp_busy;
  logic         comp_err;

  int checks = 0;
  int errors = 0;

  hdpldadapt_cmn_cp_comp_dly #(.WIDTH(W), .MAX_DLY(MAXD), .RESET_VAL(RV)) dut (
    .clk        (clk),
    .srst       (srst),
    .data_enable(de),
    .dist_tap   (tap),
    .r_comp_en  (en),
    .r_comp_dly (dly),
    .comp_out   (comp_out),
    .comp_busy  (comp_busy),
    .comp_err   (comp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: hist[0] is the newest tap taken on an enabled edge since reset.
  logic [W-1:0] hist [0:16];
  logic         m_err;
  bit           m_valid = 1'b0;

  function automatic int dm_f();
    int v = int'(dly);
    return (v > MAXD) ? MAXD : v;
  endfunction

  // Busy while any value change lies within the last D enabled pushes.
  function automatic logic m_busy();
    int d = dm_f();
    if (!en) return 1'b0;
    for (int i = 0; i < d; i++)
      if (hist[i] != hist[i+1]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [W-1:0] m_out();
    int d = dm_f();
    if (!en || d == 0) return tap;
    return hist[d-1];
  endfunction

  always @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i <= 16; i++) hist[i] = {W{RV}};
      m_err   = 1'b0;
      m_valid = 1'b1;
    end else if (de) begin
      if (ERR_EN && en && dm_f() > 0 && tap != hist[0] && m_busy()) m_err = 1'b1;
      for (int i = 16; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = tap;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_out",  32'(comp_out),  32'(m_out()));
      chk("model_busy", 32'(comp_busy), 32'(m_busy()));
      chk("model_err",  32'(comp_err),  32'(m_err));
    end
  end

  task automatic step(input logic s, input logic d, input logic [W-1:0] t,
                      input logic e, input logic [3:0] l);
    @(posedge clk);
    #1;
    srst = s; de = d; tap = t; en = e; dly = l;
    @(negedge clk);
  endtask

  // Cycles 0 and 1 are reset; the new CRAM setting is applied inside reset.
  task automatic scn_start(input logic e, input logic [3:0] l);
    step(1'b1, 1'b1, '0, en, dly);
    step(1'b1, 1'b1, '0, e, l);
  endtask

  logic [W-1:0] t;
  logic         d;

  initial begin
    srst = 1'b1; de = 1'b0; tap = '0; en = 1'b1; dly = 4'd3;

    // Single step, D=3, always enabled
    scn_start(1'b1, 4'd3);
    chk("A_rst_busy", 32'(comp_busy), 32'd0);
    chk("A_rst_out",  32'(comp_out),  32'd0);
    for (int c = 2; c < 20; c++) begin
      step(1'b0, 1'b1, (c >= 10) ? 2'd1 : 2'd0, 1'b1, 4'd3);
      if (c == 10) chk("A_busy10", 32'(comp_busy), 32'd0);
      if (c == 11) chk("A_busy11", 32'(comp_busy), 32'd1);
      if (c == 12) chk("A_out12",  32'(comp_out),  32'd0);
      if (c == 13) chk("A_out13",  32'(comp_out),  32'd1);
      if (c == 13) chk("A_busy13", 32'(comp_busy), 32'd1);
      if (c == 14) chk("A_busy14", 32'(comp_busy), 32'd0);
    end

    // Alternating enable, D=3: three enabled edges stretch over six cycles
    scn_start(1'b1, 4'd3);
    for (int c = 2; c < 22; c++) begin
      step(1'b0, (c % 2) == 0, (c >= 10) ? 2'd1 : 2'd0, 1'b1, 4'd3);
      if (c == 11) chk("B_busy11", 32'(comp_busy), 32'd1);
      if (c == 14) chk("B_out14",  32'(comp_out),  32'd0);
      if (c == 15) chk("B_out15",  32'(comp_out),  32'd1);
      if (c == 16) chk("B_busy16", 32'(comp_busy), 32'd1);
      if (c == 17) chk("B_busy17", 32'(comp_busy), 32'd0);
    end

    // Saturation: 15 requested, MAX_DLY=8
    scn_start(1'b1, 4'd15);
    for (int c = 2; c < 24; c++) begin
      step(1'b0, 1'b1, (c >= 10) ? 2'd1 : 2'd0, 1'b1, 4'd15);
      if (c == 17) chk("C_out17",  32'(comp_out),  32'd0);
      if (c == 18) chk("C_out18",  32'(comp_out),  32'd1);
      if (c == 18) chk("C_busy18", 32'(comp_busy), 32'd1);
      if (c == 19) chk("C_busy19", 32'(comp_busy), 32'd0);
    end

    // Zero delay: combinational pass-through, never busy
    scn_start(1'b1, 4'd0);
    for (int c = 2; c < 12; c++) begin
      t = 2'(c);
      step(1'b0, 1'b1, t, 1'b1, 4'd0);
      chk("Z_out", 32'(comp_out), 32'(t));
      if (c == 11) chk("Z_busy", 32'(comp_busy), 32'd0);
    end

    // Overlapping steps, D=4, then a reset clears the error flag
    scn_start(1'b1, 4'd4);
    for (int c = 2; c < 24; c++) begin
      step(c == 20, 1'b1, (c == 10 || c == 11) ? 2'd1 : 2'd0, 1'b1, 4'd4);
      if (c == 11) chk("D_busy11", 32'(comp_busy), 32'd1);
      if (c == 12) chk("D_err12",  32'(comp_err),  32'd0);
      if (c == 13) chk("D_err13",  32'(comp_err),  32'(ERR_EN));
      if (c == 13) chk("D_out13",  32'(comp_out),  32'd0);
      if (c == 14) chk("D_out14",  32'(comp_out),  32'd1);
      if (c == 15) chk("D_out15",  32'(comp_out),  32'd1);
      if (c == 16) chk("D_out16",  32'(comp_out),  32'd0);
      if (c == 16) chk("D_busy16", 32'(comp_busy), 32'd1);
      if (c == 17) chk("D_busy17", 32'(comp_busy), 32'd0);
      if (c == 19) chk("D_err19",  32'(comp_err),  32'(ERR_EN));
      if (c == 21) chk("D_err21",  32'(comp_err),  32'd0);
    end

    // Reset pulse while a step is in flight
    scn_start(1'b1, 4'd3);
    for (int c = 2; c < 20; c++) begin
      step(c == 12, 1'b1, (c >= 10) ? 2'd1 : 2'd0, 1'b1, 4'd3);
      if (c == 11) chk("E_busy11", 32'(comp_busy), 32'd1);
      if (c == 12) chk("E_out12",  32'(comp_out),  32'd0);
      if (c == 13) chk("E_busy13", 32'(comp_busy), 32'd0);
      if (c == 13) chk("E_out13",  32'(comp_out),  32'd0);
      if (c == 13) chk("E_err13",  32'(comp_err),  32'd0);
    end

    // Compensation disabled: pure pass-through under random traffic
    scn_start(1'b0, 4'd5);
    for (int c = 2; c < 42; c++) begin
      t = 2'($urandom);
      d = 1'($urandom_range(0, 1));
      step(1'b0, d, t, 1'b0, 4'd5);
      chk("F_out", 32'(comp_out), 32'(t));
    end

    // Random traffic against the model for several delays
    for (int r = 0; r < 4; r++) begin
      logic [3:0] l;
      l = 4'($urandom_range(1, 15));
      scn_start(1'b1, l);
      t = '0;
      for (int c = 2; c < 150; c++) begin
        if ($urandom_range(0, 5) == 0) t = 2'($urandom);
        d = ($urandom_range(0, 3) != 0);
        step(1'b0, d, t, 1'b1, l);
      end
    end

    step(1'b1, 1'b0, '0, en, dly);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hdpldadapt_cmn_cp_comp_dly.md
HDPLDADAPT_CMN_CP_COMP_DLY -- requirements
Module: hdpldadapt_cmn_cp_comp_dly

Interface
REQ-001 SHALL have parameter WIDTH, default 1: control width, equal to the WIDTH of the upstream distribution stage.
REQ-002 SHALL have parameter MAX_DLY, default 15: delay-line depth in enabled cycles, legal range 1..15.
REQ-003 SHALL have parameter RESET_VAL, default 1'b0: reset value replicated across all WIDTH bits.
REQ-004 SHALL have port clk  input  1: block clock; the only clock.
REQ-005 SHALL have port srst  input  1: reset, synchronous and active-high.
REQ-006 SHALL have port data_enable  input  1: advance qualifier, the same strobe that drives the distribution stage.
REQ-007 SHALL have port dist_tap  input  WIDTH: per-channel tap from the distribution stage.
REQ-008 SHALL have port r_comp_en  input  1: CRAM; 1 = compensate, 0 = pass-through.
REQ-009 SHALL have port r_comp_dly  input  4: CRAM; compensation delay in enabled cycles.
REQ-010 SHALL have port comp_out  output  WIDTH: compensated control to the channel datapath.
REQ-011 SHALL have port comp_busy  output  1: a captured transition is still in flight.
REQ-012 SHALL have port comp_err  output  1: sticky overlap error flag.

Function
REQ-013 SHALL hold a delay line stg[1..MAX_DLY] of WIDTH bits each; on a clk edge with data_enable=1, stg[1] takes dist_tap and stg[k] takes stg[k-1]; with data_enable=0 all stages hold.
REQ-014 SHALL define the effective delay D as min(r_comp_dly, MAX_DLY); values above MAX_DLY saturate.
REQ-015 SHALL drive comp_out = dist_tap combinationally when r_comp_en=0 or D=0.
REQ-016 SHALL otherwise drive comp_out = stg[D], i.e. dist_tap as it stood D enabled cycles earlier.
REQ-017 SHALL implement the FSM with two states, IDLE and PEND, and a 4-bit down-counter cnt.
REQ-018 SHALL treat a transition as captured when data_enable=1 and dist_tap != stg[1], evaluated only when r_comp_en=1 and D>0.
REQ-019 SHALL, in IDLE, on a captured transition, move to PEND and load cnt = D-1.
REQ-020 SHALL, in PEND with data_enable=1 and cnt=0, return to IDLE, unless a captured transition occurs in the same cycle, in which case it stays in PEND with cnt = D-1.
REQ-021 SHALL, in PEND with data_enable=1 and cnt>0, decrement cnt; a captured transition in that cycle reloads cnt = D-1 instead.
REQ-022 SHALL hold the FSM and cnt whenever data_enable=0.
REQ-023 SHALL assert comp_busy iff the state is PEND; comp_busy is registered with 1-cycle latency from the capture edge.
REQ-024 SHALL, when r_comp_en=0, force the FSM to IDLE on the next clk edge, while the delay line keeps shifting.
REQ-025 SHALL require r_comp_en and r_comp_dly changes only while srst=1; behaviour under mid-operation CRAM changes is unspecified apart from REQ-024.

Reset
REQ-026 SHALL, on a clk edge with srst=1, load all stg to RESET_VAL, set the state to IDLE, cnt to 0, and comp_err to 0; srst takes priority over data_enable.
REQ-027 SHALL give the following values during and after reset: comp_busy=0, comp_err=0, and comp_out per REQ-015/016 (RESET_VAL replicated when compensating).
REQ-028 SHALL abandon an in-flight PEND on reset assertion with no residual pulse on comp_out.

Configuration
REQ-029 SHALL, with macro HDPLDADAPT_CP_COMP_ERR_EN defined, set comp_err on a captured transition that occurs while in PEND, and hold it until srst.
REQ-030 SHALL, without HDPLDADAPT_CP_COMP_ERR_EN, tie comp_err to 0 and instantiate no error logic; all other behaviour is identical.

Verification
REQ-031 SHALL cover: r_comp_en=1, r_comp_dly=3, data_enable=1 constant, dist_tap 0->1 at cycle 10 -> comp_out rises at cycle 13, comp_busy high for cycles 11..13.
REQ-032 SHALL cover: r_comp_dly=3, data_enable toggling 1,0,1,0..., single step on dist_tap -> comp_out follows after exactly 3 enabled edges, and cnt holds on disabled cycles.
REQ-033 SHALL cover: r_comp_dly=15 with MAX_DLY=8 -> delay is 8 cycles (saturation); r_comp_dly=0 -> comp_out equals dist_tap in the same cycle, comp_busy stays 0.
REQ-034 SHALL cover: r_comp_dly=4, dist_tap steps at cycles 10 and 12 -> comp_out steps at 14 and 16, comp_busy high 11..16, comp_err=1 from cycle 13 with the macro and 0 without.
REQ-035 SHALL cover: srst pulsed for 1 cycle at cycle 12 during the REQ-031 sequence -> comp_busy=0 and comp_out=RESET_VAL from cycle 13, no rise at cycle 13, comp_err cleared.
REQ-036 SHALL cover: r_comp_en=0 with random dist_tap -> comp_out equals dist_tap every cycle, comp_busy=0 and comp_err=0 throughout.
